// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, NOP/HALT encodings, FSM states.
package fetch_stage_pkg;

    localparam int          DEF_WIDTH    = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INSTR    = 16'h0800;
    localparam logic [4:0]  HALT_OPC     = 5'b00000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/PC+2 buffer catching a fetch that returns while decode is stalled.
module fetch_hold_buf
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             unload,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_instr,
    input  logic [WIDTH-1:0] d_pc2,
    output logic             vld,
    output logic [WIDTH-1:0] q_instr,
    output logic [WIDTH-1:0] q_pc2
);

    logic             vld_r;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] pc2_r;

    // Entry storage; flush beats load beats unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r   <= 1'b0;
            instr_r <= WIDTH'(NOP_INSTR);
            pc2_r   <= {WIDTH{1'b0}};
        end else if (flush) begin
            vld_r <= 1'b0;
        end else if (load) begin
            vld_r   <= 1'b1;
            instr_r <= d_instr;
            pc2_r   <= d_pc2;
        end else if (unload) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= vld_r;
        end
    end

    assign vld     = vld_r;
    assign q_instr = instr_r;
    assign q_pc2   = pc2_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID register, redirect/stall/halt handling.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign output.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_sel,
    input  logic [WIDTH-1:0] pc_target,
    input  logic             halt,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc2_out,
    output logic [4:0]       opcode_out,
    output logic             valid_out,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic             fetch_misalign,
`endif
    output logic             halted
);

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(2);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    fetch_state_t     state_r;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] redir_tgt_r;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] pc2_r;
    logic             valid_r;
    logic             req_r;
    logic             halted_r;
    logic             redir_pend_r;
    logic             halt_pend_r;

    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] tgt_s;
    logic             halt_take_s;
    logic             redir_take_s;
    logic             done_s;
    logic             hold_load_s;
    logic             hold_unload_s;
    logic             hold_flush_s;
    logic             hold_vld_s;
    logic [WIDTH-1:0] hold_instr_s;
    logic [WIDTH-1:0] hold_pc2_s;

    assign pc_inc_s = pc_r + PC_STEP;
    assign tgt_s    = pc_target & ALIGN_MASK;

    // Event decode with priority halt > redirect > stall > sequential.
    always_comb begin
        halt_take_s   = halt && valid_r && (state_r != HALTED) && !halt_pend_r;
        redir_take_s  = pc_sel && !halt_take_s && !halt_pend_r && (state_r != HALTED);
        done_s        = (state_r == WAIT) && imem_ready;
        hold_flush_s  = redir_take_s || halt_take_s;
        hold_load_s   = done_s && stall && !hold_flush_s && !redir_pend_r && !halt_pend_r;
        hold_unload_s = (state_r == FETCH) && !stall && hold_vld_s && !hold_flush_s;
    end

    fetch_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hold_load_s),
        .unload  (hold_unload_s),
        .flush   (hold_flush_s),
        .d_instr (imem_rdata),
        .d_pc2   (pc_inc_s),
        .vld     (hold_vld_s),
        .q_instr (hold_instr_s),
        .q_pc2   (hold_pc2_s)
    );

    // Fetch FSM; imem_addr is pc_r itself, so it cannot move while an access is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            redir_tgt_r  <= {WIDTH{1'b0}};
            instr_r      <= WIDTH'(NOP_INSTR);
            pc2_r        <= {WIDTH{1'b0}};
            valid_r      <= 1'b0;
            req_r        <= 1'b0;
            halted_r     <= 1'b0;
            redir_pend_r <= 1'b0;
            halt_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (halt_take_s) begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                        valid_r  <= 1'b0;
                        req_r    <= 1'b0;
                    end else if (redir_take_s) begin
                        pc_r    <= tgt_s;
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= WAIT;
                    end else if (!stall) begin
                        req_r   <= 1'b1;
                        state_r <= WAIT;
                        if (hold_vld_s) begin
                            instr_r <= hold_instr_s;
                            pc2_r   <= hold_pc2_s;
                            valid_r <= 1'b1;
                            pc_r    <= pc_inc_s;
                        end else begin
                            valid_r <= 1'b0;
                        end
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (halt_take_s || halt_pend_r) begin
                        // The memory handshake is always finished; the returned word is discarded.
                        valid_r <= 1'b0;
                        if (imem_ready) begin
                            state_r      <= HALTED;
                            req_r        <= 1'b0;
                            halted_r     <= 1'b1;
                            halt_pend_r  <= 1'b0;
                            redir_pend_r <= 1'b0;
                        end else begin
                            halt_pend_r <= 1'b1;
                        end
                    end else if (redir_take_s) begin
                        valid_r <= 1'b0;
                        if (imem_ready) begin
                            pc_r         <= tgt_s;
                            redir_pend_r <= 1'b0;
                        end else begin
                            redir_pend_r <= 1'b1;
                            redir_tgt_r  <= tgt_s;
                        end
                    end else if (imem_ready) begin
                        if (redir_pend_r) begin
                            redir_pend_r <= 1'b0;
                            pc_r         <= redir_tgt_r;
                            valid_r      <= 1'b0;
                            if (stall) begin
                                req_r   <= 1'b0;
                                state_r <= FETCH;
                            end else begin
                                req_r <= 1'b1;
                            end
                        end else if (stall) begin
                            req_r   <= 1'b0;
                            state_r <= FETCH;
                        end else begin
                            instr_r <= imem_rdata;
                            pc2_r   <= pc_inc_s;
                            valid_r <= 1'b1;
                            pc_r    <= pc_inc_s;
                        end
                    end else if (!stall) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                HALTED: begin
                    req_r    <= 1'b0;
                    valid_r  <= 1'b0;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r <= FETCH;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_r;

    // Sticky record of any accepted redirect to an odd address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if (redir_take_s && pc_target[0]) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign fetch_misalign = misalign_r;
`endif

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign instr_out  = instr_r;
    assign pc2_out    = pc2_r;
    assign opcode_out = instr_r[WIDTH-1:WIDTH-5];
    assign valid_out  = valid_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table, directed corner sequences, randomized stream check.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_sel, halt, stall, imem_req, imem_ready, valid_out, halted;
    logic [15:0] pc_target, imem_addr, imem_rdata, instr_out, pc2_out;
    logic [4:0]  opcode_out;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .pc_target(pc_target), .halt(halt),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instr_out(instr_out), .pc2_out(pc2_out),
        .opcode_out(opcode_out), .valid_out(valid_out),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          waits   = 0;
    int          wcnt    = 0;
    bit          rand_mem = 1'b0;
    bit          pend_q  = 1'b0;
    logic [15:0] hold_addr_q;

    typedef struct {
        logic        stall;
        logic        pc_sel;
        logic [15:0] tgt;
        logic        halt;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        hlt;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of the memory model: protocol check, respond, advance to next negedge.
    task automatic tick();
        if (pend_q) begin
            chk("req_held_while_waiting", {31'b0, imem_req}, 32'd1);
            chk("addr_stable_while_waiting", {16'b0, imem_addr}, {16'b0, hold_addr_q});
        end
        if (rand_mem) imem_ready = imem_req && ($urandom_range(0, 2) == 0);
        else          imem_ready = imem_req && (wcnt >= waits);
        imem_rdata  = imem_req ? mem[imem_addr[15:1]] : 16'h0000;
        pend_q      = imem_req && !imem_ready;
        hold_addr_q = imem_addr;
        if (imem_req) wcnt = imem_ready ? 0 : wcnt + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; pc_sel = 1'b0; halt = 1'b0; pc_target = 16'h0000;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        wcnt = 0; pend_q = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ti;
        logic [15:0] exp_pc;
        int          idle, deliveries, got;

        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2) ^ 16'h5A00;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0800;

        //        stall pc_sel tgt      halt  req  addr     vld  instr    pc2      hlt
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0800, 16'h0002, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0800, 16'h0004, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0800, 16'h0006, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0800, 16'h0008, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0800, 16'h0008, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0800, 16'h0008, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0800, 16'h0008, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h5A08, 16'h000A, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1, 16'h5A40, 16'h0042, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0012, 1'b1, 16'h5A10, 16'h0012, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};

        // Reset values while rst_n is held low.
        waits = 0;
        rst_n = 1'b0;
        stall = 1'b0; pc_sel = 1'b0; halt = 1'b0; pc_target = 16'h0000;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_instr_nop", {16'b0, instr_out}, 32'h0800);
        chk("rst_pc2", {16'b0, pc2_out}, 32'd0);
        chk("rst_opcode", {27'b0, opcode_out}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif

        // Zero-wait cycle table: sequential, stall/hold, redirect, redirect+stall, halt.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            stall = tbl[i].stall; pc_sel = tbl[i].pc_sel; pc_target = tbl[i].tgt; halt = tbl[i].halt;
            tick();
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("tbl%0d_valid", i), {31'b0, valid_out}, {31'b0, tbl[i].vld});
            chk($sformatf("tbl%0d_halted", i), {31'b0, halted}, {31'b0, tbl[i].hlt});
            if (tbl[i].req)
                chk($sformatf("tbl%0d_addr", i), {16'b0, imem_addr}, {16'b0, tbl[i].addr});
            if (tbl[i].vld) begin
                ti = tbl[i].instr;
                chk($sformatf("tbl%0d_instr", i), {16'b0, instr_out}, {16'b0, ti});
                chk($sformatf("tbl%0d_pc2", i), {16'b0, pc2_out}, {16'b0, tbl[i].pc2});
                chk($sformatf("tbl%0d_opcode", i), {27'b0, opcode_out}, {27'b0, ti[15:11]});
            end
        end
        stall = 1'b0; pc_sel = 1'b0; halt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_sticky", {31'b0, fetch_misalign}, 32'd1);
`endif

        // Reset after halt refetches from the reset PC.
        do_reset();
        chk("rearm_halted", {31'b0, halted}, 32'd0);
        tick();
        chk("rearm_req", {31'b0, imem_req}, 32'd1);
        chk("rearm_addr", {16'b0, imem_addr}, 32'd0);

        // Two-wait memory: each address held 3 cycles, one valid pulse per access.
        do_reset();
        waits = 2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("w2_req_c%0d", k), {31'b0, imem_req}, 32'd1);
            chk($sformatf("w2_addr_c%0d", k), {16'b0, imem_addr}, 32'(2 * ((k - 1) / 3)));
            chk($sformatf("w2_valid_c%0d", k), {31'b0, valid_out}, {31'b0, (k >= 4) && ((k - 1) % 3 == 0)});
            if (valid_out) chk($sformatf("w2_pc2_c%0d", k), {16'b0, pc2_out}, 32'(2 * ((k - 1) / 3)));
        end
        // Asynchronous reset mid-access drops the request without a clock edge.
        #2 rst_n = 1'b0;
        #1 chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'b0, valid_out}, 32'd0);

        // Redirect while an access is outstanding: data dropped, next address is the target.
        do_reset();
        waits = 2;
        tick();
        pc_sel = 1'b1; pc_target = 16'h0040;
        tick();
        pc_sel = 1'b0;
        chk("rdw_addr_held1", {16'b0, imem_addr}, 32'd0);
        chk("rdw_valid1", {31'b0, valid_out}, 32'd0);
        tick();
        chk("rdw_addr_held2", {16'b0, imem_addr}, 32'd0);
        chk("rdw_valid2", {31'b0, valid_out}, 32'd0);
        tick();
        chk("rdw_valid3", {31'b0, valid_out}, 32'd0);
        chk("rdw_new_addr", {16'b0, imem_addr}, 32'h0040);
        got = 0;
        for (int k = 0; k < 6 && !valid_out; k++) tick();
        chk("rdw_target_instr", {16'b0, instr_out}, {16'b0, mem[16'h0020]});
        chk("rdw_target_pc2", {16'b0, pc2_out}, 32'h0042);

        // Halt with an access outstanding: handshake completes, then permanently idle.
        do_reset();
        waits = 2;
        for (int k = 0; k < 10 && !valid_out; k++) tick();
        chk("halt_pre_valid", {31'b0, valid_out}, 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_pend_valid", {31'b0, valid_out}, 32'd0);
        chk("halt_pend_req", {31'b0, imem_req}, 32'd1);
        chk("halt_pend_halted", {31'b0, halted}, 32'd0);
        for (int k = 0; k < 10 && !halted; k++) tick();
        chk("halt_reached", {31'b0, halted}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("halt_idle_req%0d", k), {31'b0, imem_req}, 32'd0);
            chk($sformatf("halt_idle_valid%0d", k), {31'b0, valid_out}, 32'd0);
        end

        // Sequential wrap at the top of the address space.
        do_reset();
        waits = 0;
        tick();
        pc_sel = 1'b1; pc_target = 16'hFFFE;
        tick();
        pc_sel = 1'b0;
        chk("wrap_addr_top", {16'b0, imem_addr}, 32'hFFFE);
        tick();
        chk("wrap_addr_zero", {16'b0, imem_addr}, 32'h0000);
        chk("wrap_valid", {31'b0, valid_out}, 32'd1);
        chk("wrap_pc2", {16'b0, pc2_out}, 32'h0000);
        chk("wrap_instr", {16'b0, instr_out}, {16'b0, mem[15'h7FFF]});

        // Random memory latency, stalls and redirects against an in-order stream model.
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        do_reset();
        rand_mem = 1'b1;
        exp_pc = 16'h0000;
        idle = 0;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            stall  = ($urandom_range(0, 3) == 0);
            pc_sel = 1'b0;
            if (valid_out && !stall) begin
                chk("stream_instr", {16'b0, instr_out}, {16'b0, mem[exp_pc[15:1]]});
                chk("stream_pc2", {16'b0, pc2_out}, {16'b0, exp_pc + 16'd2});
                exp_pc = exp_pc + 16'd2;
                deliveries++;
                idle = 0;
                if ($urandom_range(0, 7) == 0) begin
                    pc_sel    = 1'b1;
                    pc_target = 16'($urandom_range(0, 4095));
                    exp_pc    = pc_target & 16'hFFFE;
                end
            end else begin
                idle++;
            end
            if (idle > 60) begin
                chk("stream_progress_idle_cycles", 32'(idle), 32'd0);
                idle = 0;
            end
            tick();
        end
        chk("stream_enough_deliveries", {31'b0, deliveries > 100}, 32'd1);
        stall = 1'b0; pc_sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
